// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: EX operand forwarding selects and load-use stall control; optional perf counters via HAZ_PERF_CNT_EN
module hazard_forward_unit #(
    parameter int AW         = 5,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   id_valid,
    input  logic [NUM_SRC*AW-1:0]  id_rs,
    input  logic [NUM_SRC*AW-1:0]  ex_rs,
    input  logic [AW-1:0]          ex_rd,
    input  logic                   ex_regwr,
    input  logic                   ex_memrd,
    input  logic [AW-1:0]          mem_rd,
    input  logic                   mem_regwr,
    input  logic [AW-1:0]          wb_rd,
    input  logic                   wb_regwr,
    output logic [2*NUM_SRC-1:0]   fwd_sel,
    output logic                   stall_pc,
    output logic                   stall_ifid,
    output logic                   bubble_idex,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       fwd_cnt
);
    typedef enum logic {IDLE, STALL} state_t;
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       hit, match, stall;
    // per-operand forwarding; EX/MEM beats MEM/WB, x0 never forwarded
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++)
            fwd_sel[2*i +: 2] = (mem_regwr && mem_rd != '0 && mem_rd == ex_rs[i*AW +: AW]) ? 2'b10 :
                                (wb_regwr && wb_rd != '0 && wb_rd == ex_rs[i*AW +: AW]) ? 2'b01 : 2'b00;
    end
    // load-use detection against any ID source operand
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < NUM_SRC; i++)
            match = match | (ex_rd == id_rs[i*AW +: AW]);
        hit = id_valid && ex_memrd && ex_regwr && ex_rd != '0 && match;
    end
    // stall sequencing: first stall cycle comes from IDLE, the rest count down in STALL
    always_comb begin
        stall   = !flush && (state_q == STALL || hit);
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == IDLE) begin
            if (hit && LOAD_STALL > 1) begin
                state_d = STALL;
                cnt_d   = 4'(LOAD_STALL - 1);
            end
        end else if (cnt_q == 4'd1) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q - 4'd1;
        end
    end
    // state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    assign stall_pc    = stall;
    assign stall_ifid  = stall;
    assign bubble_idex = stall;
`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;
    // saturating event counters
    always_comb begin
        stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        fwd_cnt_d   = (|fwd_sel && fwd_cnt_q != '1) ? fwd_cnt_q + 1'b1 : fwd_cnt_q;
    end
    // counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end
    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`else
    assign stall_cnt = '0;
    assign fwd_cnt   = '0;
`endif
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: scoreboard bench driving LOAD_STALL=1 and LOAD_STALL=3 instances in parallel
module tb_hazard_forward_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0, id_valid = 1'b0;
    logic [9:0]  id_rs = '0, ex_rs = '0;
    logic [4:0]  ex_rd = '0, mem_rd = '0, wb_rd = '0;
    logic        ex_regwr = 1'b0, ex_memrd = 1'b0, mem_regwr = 1'b0, wb_regwr = 1'b0;
    logic [3:0]  fwd_a, fwd_b;
    logic        spc_a, sif_a, bub_a, spc_b, sif_b, bub_b;
    logic [3:0]  scnt_a, fcnt_a;
    logic [31:0] scnt_b, fcnt_b;
    int          n_cmp = 0, n_err = 0;
`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    typedef struct {
        string       nm;
        logic [3:0]  fwd;
        logic        sa, sb, cc;
        logic [31:0] ca, cb;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    hazard_forward_unit #(.LOAD_STALL(1), .CNT_W(4)) u_a (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_rs(id_rs), .ex_rs(ex_rs),
        .ex_rd(ex_rd), .ex_regwr(ex_regwr), .ex_memrd(ex_memrd), .mem_rd(mem_rd), .mem_regwr(mem_regwr),
        .wb_rd(wb_rd), .wb_regwr(wb_regwr), .fwd_sel(fwd_a), .stall_pc(spc_a), .stall_ifid(sif_a),
        .bubble_idex(bub_a), .stall_cnt(scnt_a), .fwd_cnt(fcnt_a));

    hazard_forward_unit #(.LOAD_STALL(3)) u_b (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_rs(id_rs), .ex_rs(ex_rs),
        .ex_rd(ex_rd), .ex_regwr(ex_regwr), .ex_memrd(ex_memrd), .mem_rd(mem_rd), .mem_regwr(mem_regwr),
        .wb_rd(wb_rd), .wb_regwr(wb_regwr), .fwd_sel(fwd_b), .stall_pc(spc_b), .stall_ifid(sif_b),
        .bubble_idex(bub_b), .stall_cnt(scnt_b), .fwd_cnt(fcnt_b));

    task automatic chk(string nm, logic [31:0] act, logic [31:0] e);
        n_cmp++;
        if (act !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expc(string nm, logic [3:0] f, logic sa, logic sb, logic cc, logic [31:0] ca, logic [31:0] cb);
        exp_t e;
        e.nm = nm; e.fwd = f; e.sa = sa; e.sb = sb; e.cc = cc;
        e.ca = PERF ? ca : 32'd0;
        e.cb = PERF ? cb : 32'd0;
        sbq.push_back(e);
    endtask

    task automatic exp(string nm, logic [3:0] f, logic sa, logic sb);
        expc(nm, f, sa, sb, 1'b0, 32'd0, 32'd0);
    endtask

    always @(negedge clk) begin
        if (sbq.size() != 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk({e.nm, ".fwd_a"}, 32'(fwd_a), 32'(e.fwd));
            chk({e.nm, ".fwd_b"}, 32'(fwd_b), 32'(e.fwd));
            chk({e.nm, ".stall_a"}, {29'd0, spc_a, sif_a, bub_a}, {29'd0, {3{e.sa}}});
            chk({e.nm, ".stall_b"}, {29'd0, spc_b, sif_b, bub_b}, {29'd0, {3{e.sb}}});
            if (e.cc) begin
                chk({e.nm, ".stall_cnt_a"}, 32'(scnt_a), e.ca);
                chk({e.nm, ".stall_cnt_b"}, scnt_b, e.cb);
            end
        end
    end

    initial begin
        tick(); expc("reset", 4'b0000, 0, 0, 1, 0, 0);
        tick(); rst = 0; exp("post_reset", 4'b0000, 0, 0);
        tick(); mem_regwr = 1; mem_rd = 5; ex_rs = {5'd0, 5'd5}; wb_rd = 5; wb_regwr = 1; exp("ex_wins", 4'b0010, 0, 0);
        tick(); mem_regwr = 0; exp("wb_fwd", 4'b0001, 0, 0);
        tick(); mem_rd = 0; ex_rs = {5'd7, 5'd0}; mem_regwr = 1; wb_rd = 7; wb_regwr = 0; exp("x0_nowr", 4'b0000, 0, 0);
        tick(); wb_regwr = 1; exp("wb_op1", 4'b0100, 0, 0);
        tick(); mem_rd = 4; ex_rs = {5'd4, 5'd4}; wb_rd = 4; exp("both_ex", 4'b1010, 0, 0);
        tick(); mem_regwr = 0; wb_rd = 0; ex_rs = '0; exp("wb_x0", 4'b0000, 0, 0);
        tick(); id_valid = 1; ex_memrd = 1; ex_regwr = 1; ex_rd = 3; id_rs = {5'd3, 5'd0}; exp("lu1", 4'b0000, 1, 1);
        tick(); ex_memrd = 0; exp("lu2", 4'b0000, 0, 1);
        tick(); exp("lu3", 4'b0000, 0, 1);
        tick(); exp("lu4", 4'b0000, 0, 0);
        tick(); ex_memrd = 1; id_valid = 0; exp("novalid", 4'b0000, 0, 0);
        tick(); id_valid = 1; ex_regwr = 0; exp("noregwr", 4'b0000, 0, 0);
        tick(); ex_regwr = 1; ex_rd = 0; id_rs = '0; exp("rd0", 4'b0000, 0, 0);
        tick(); ex_rd = 3; id_rs = {5'd0, 5'd3}; flush = 1; exp("flush_idle", 4'b0000, 0, 0);
        tick(); flush = 0; exp("op0_hit", 4'b0000, 1, 1);
        tick(); ex_memrd = 0; flush = 1; exp("flush_stall", 4'b0000, 0, 0);
        tick(); flush = 0; exp("after_flush", 4'b0000, 0, 0);
        tick(); ex_memrd = 1; exp("rst_hit", 4'b0000, 1, 1);
        tick(); ex_memrd = 0; rst = 1; exp("rst_mid", 4'b0000, 0, 1);
        tick(); rst = 0; expc("rst_after", 4'b0000, 0, 0, 1, 0, 0);
        tick(); ex_memrd = 1; exp("re_hit", 4'b0000, 1, 1);
        tick(); ex_memrd = 0; exp("re2", 4'b0000, 0, 1);
        tick(); exp("re3", 4'b0000, 0, 1);
        tick(); exp("re4", 4'b0000, 0, 0);
        tick(); rst = 1; exp("rst6", 4'b0000, 0, 0);
        tick(); rst = 0; ex_memrd = 1; expc("sat", 4'b0000, 1, 1, 1, 0, 0);
        for (int k = 2; k <= 20; k++) begin
            tick(); expc("sat", 4'b0000, 1, 1, 1, (k - 1 > 15) ? 32'd15 : 32'(k - 1), 32'(k - 1));
        end
        tick(); ex_memrd = 0; expc("sat_end", 4'b0000, 0, 1, 1, 15, 20);
        tick(); expc("sat_idle", 4'b0000, 0, 0, 1, 15, 21);
        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
        if (sbq.size() != 0) chk("drain", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
